cheese_spawn_ctrl: RTL and testbench
====================================

# cheese_spawn_ctrl

Controller that sequences the two cheese slots of the game. It detects Tom/Jerry pickups, scores them, and hides an eaten cheese for a respawn delay. It then requests a new position from the platform random-position generator through its one-hot `rnd_generate` port. It sits between the collision logic of both characters and `randomx_plat`, and also drives cheese visibility to the draw pipeline and scores to the HUD.

## Interface
- `RESPAWN_DELAY`, default `game_pkg::CHEESE_RESPAWN_CYC` (32_500_000): cycles a slot stays hidden after being eaten; must be ≥1
- `SCORE_W`, default 8: score counter width
- `MAX_SCORE`, default 10: score that ends the game; must be ≤ 2^SCORE_W−1
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `game_en`  in  1  level; game running
- `tom_hit`  in  2  bit i = Tom overlaps cheese i this cycle
- `jerry_hit`  in  2  bit i = Jerry overlaps cheese i this cycle
- `rnd_generate`  out  2  one-hot regenerate pulse to `randomx_plat`; bit0 = cheese 1, bit1 = cheese 2
- `cheese_vis`  out  2  bit i = cheese i drawn and collectable
- `tom_score`  out  SCORE_W  Tom's score
- `jerry_score`  out  SCORE_W  Jerry's score
- `game_over`  out  1  sticky; a score has reached MAX_SCORE
- `winner`  out  2  01 = Tom, 10 = Jerry, 00 = none

## Operation
- Per-slot FSM states: IDLE, VISIBLE, HIDDEN, REQ, PULSE, SETTLE, HALT.
- IDLE: `cheese_vis[i]`=0. Moves to VISIBLE when `game_en`=1 and `game_over`=0. The generator holds initial positions after its reset, so no pulse is issued.
- VISIBLE: `cheese_vis[i]`=1.
  - If `tom_hit[i]` or `jerry_hit[i]`: credit one point, load the delay counter with RESPAWN_DELAY−1, go to HIDDEN.
  - If both players hit the same slot in the same cycle, the tie goes to the player who did not win the previous tie. A shared `tie_last` register is updated only on ties; after reset the first tie goes to Tom.
- HIDDEN: counter decrements each cycle; at 0 go to REQ.
- REQ: waits for a spawn grant, then goes to PULSE.
  - Spawn arbiter: at most one bit of `rnd_generate` is ever high, because `randomx_plat` ignores 2'b11.
  - If both slots are in REQ, grant the slot not granted last. After reset, slot 0 wins the first conflict.
- PULSE: `rnd_generate[i]`=1 for exactly this cycle; go to SETTLE.
- SETTLE: one cycle so the generator's registered position is valid; then VISIBLE.
- Scoring:
  - Each score adds the number of slots credited to that player this cycle (0..2), saturating at MAX_SCORE.
  - When either score reaches MAX_SCORE, `game_over` is set on the same edge. If both reach it in the same cycle, the higher score wins; on equal scores, Tom wins. `winner` is set on that edge.
  - While `game_over`=1 all slots go to HALT: `cheese_vis`=0, no pulses, hits ignored. HALT and `game_over` are left only by `rst`.
- `game_en` deasserted: all non-HALT slots return to IDLE next edge. Delay counters and any pending REQ are discarded. Scores hold.
- Hits in any state other than VISIBLE are ignored.

## Timing
- Reset values: `rnd_generate`=00, `cheese_vis`=00, scores=0, `game_over`=0, `winner`=00, slots IDLE, `tie_last`=Jerry, spawn pointer=slot 1.
- All outputs are registered.
- Hit sampled at edge N: at N+1, score updated and `cheese_vis[i]`=0.
- With an uncontested grant, `rnd_generate[i]` is high in cycle N+1+RESPAWN_DELAY+1, and `cheese_vis[i]` rises two cycles after the pulse.
- A losing REQ slot is delayed by exactly one cycle per lost arbitration.
- `rst` asserted mid-operation forces reset values asynchronously; a pulse in flight is truncated.

## Structure
- `game_pkg`: slot-state enum `cheese_state_t`, `CHEESE_RESPAWN_CYC`, `CHEESE_MAX_SCORE`.
- Sub-module `cheese_slot_fsm`, instantiated twice:
  - Contains the state register and delay counter of width $clog2(RESPAWN_DELAY+1).
  - Inputs: hit, grant, game_en, halt.
  - Outputs: vis, req, pulse.
- Top level holds the tie register, the spawn arbiter, score adders and game-over/winner logic.

## Test plan
- RESPAWN_DELAY=4, `game_en`=1, `tom_hit`=01 for one cycle: `tom_score`=1 next cycle; `cheese_vis`=10; `rnd_generate`=01 for one cycle six cycles after the hit edge; `cheese_vis`=11 two cycles later.
- `tom_hit`=01 and `jerry_hit`=01 in the same cycle, repeated on the next respawn: first point to Tom, second to Jerry.
- Both slots eaten in the same cycle (`tom_hit`=11): `tom_score`+2; pulses 01 then 10 on consecutive cycles, never 11.
- MAX_SCORE=3, Jerry collects three times: after the third hit `game_over`=1, `winner`=10, `cheese_vis`=00; further hits and elapsed delays produce no pulses.
- `game_en` dropped while slot 0 is HIDDEN: slot returns to IDLE, no pulse is issued; scores are unchanged. On re-enable the cheese is visible one cycle later.
- `rst` pulsed during PULSE: `rnd_generate` goes to 00 immediately, and all outputs take their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and the cheese slot state type.
package game_pkg;

    localparam int CHEESE_RESPAWN_CYC = 32_500_000;
    localparam int CHEESE_MAX_SCORE   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VISIBLE,
        ST_HIDDEN,
        ST_REQ,
        ST_PULSE,
        ST_SETTLE,
        ST_HALT
    } cheese_state_t;

endpackage

// File: rtl/cheese_slot_fsm.sv
// One cheese slot: visibility, respawn delay, spawn request and regenerate pulse.
module cheese_slot_fsm
    import game_pkg::*;
#(
    parameter int RESPAWN_DELAY = CHEESE_RESPAWN_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hit,
    input  logic       i_grant,
    input  logic       i_game_en,
    input  logic       i_halt,
    output logic       o_vis,
    output logic       o_req,
    output logic       o_pulse,
    output logic [2:0] o_state
);

    localparam int CNT_W = $clog2(RESPAWN_DELAY + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(RESPAWN_DELAY - 1);

    cheese_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vis;
    logic             r_pulse;

    // Spawn handshake: o_req is held high for as long as the slot sits in REQ;
    // i_grant is acted on only in a cycle where o_req is high, and the slot
    // leaves REQ on that same edge, so one grant yields exactly one pulse.
    assign o_req   = (r_state == ST_REQ);
    assign o_vis   = r_vis;
    assign o_pulse = r_pulse;
    assign o_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vis   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_vis   <= 1'b0;
            r_pulse <= 1'b0;
            if (i_halt) begin
                r_state <= ST_HALT;
            end else if (!i_game_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_VISIBLE;
                        r_vis   <= 1'b1;
                    end
                    ST_VISIBLE: begin
                        if (i_hit) begin
                            r_state <= ST_HIDDEN;
                            r_cnt   <= LOAD;
                        end else begin
                            r_vis <= 1'b1;
                        end
                    end
                    ST_HIDDEN: begin
                        if (r_cnt == '0) r_state <= ST_REQ;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                    ST_REQ: begin
                        if (i_grant) begin
                            r_state <= ST_PULSE;
                            r_pulse <= 1'b1;
                        end
                    end
                    ST_PULSE:  r_state <= ST_SETTLE;
                    // Generator position register needs this cycle to settle.
                    ST_SETTLE: begin
                        r_state <= ST_VISIBLE;
                        r_vis   <= 1'b1;
                    end
                    ST_HALT:   r_state <= ST_HALT;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/cheese_spawn_ctrl.sv
// Sequences both cheese slots: pickup scoring with tie alternation, spawn
// arbitration towards randomx_plat, and sticky game-over/winner.
module cheese_spawn_ctrl
    import game_pkg::*;
#(
    parameter int RESPAWN_DELAY = CHEESE_RESPAWN_CYC,
    parameter int SCORE_W       = 8,
    parameter int MAX_SCORE     = CHEESE_MAX_SCORE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic [1:0]         tom_hit,
    input  logic [1:0]         jerry_hit,
    output logic [1:0]         rnd_generate,
    output logic [1:0]         cheese_vis,
    output logic [SCORE_W-1:0] tom_score,
    output logic [SCORE_W-1:0] jerry_score,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [5:0]         o_dbg_state
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W:0]   MAX_W = {1'b0, MAX_S};

    logic [SCORE_W-1:0] r_tom_score;
    logic [SCORE_W-1:0] r_jerry_score;
    logic               r_game_over;
    logic [1:0]         r_winner;
    logic               r_tie_last;    // 1 = Jerry won the previous tie
    logic               r_last_grant;  // 1 = slot 1 was granted last

    logic [1:0]         w_vis;
    logic [1:0]         w_req;
    logic [1:0]         w_pulse;
    logic [1:0]         w_grant;
    logic [1:0]         w_hit;
    logic [1:0]         w_act;
    logic [1:0]         w_tom_cred;
    logic [1:0]         w_jerry_cred;
    logic               w_tie_nxt;
    logic [SCORE_W:0]   w_tom_sum;
    logic [SCORE_W:0]   w_jerry_sum;
    logic [SCORE_W-1:0] w_tom_nxt;
    logic [SCORE_W-1:0] w_jerry_nxt;
    logic               w_go_nxt;
    logic               w_run;
    logic [2:0]         w_state0;
    logic [2:0]         w_state1;

    assign w_hit  = tom_hit | jerry_hit;
    assign w_run  = game_en & ~r_game_over;
    assign w_act  = w_vis & w_hit & {2{w_run}};

    // Slot 0 is resolved before slot 1, so two ties in one cycle split.
    always_comb begin
        w_tom_cred   = '0;
        w_jerry_cred = '0;
        w_tie_nxt    = r_tie_last;
        for (int i = 0; i < 2; i++) begin
            if (w_act[i]) begin
                if (tom_hit[i] && jerry_hit[i]) begin
                    if (w_tie_nxt) begin
                        w_tom_cred[i] = 1'b1;
                        w_tie_nxt     = 1'b0;
                    end else begin
                        w_jerry_cred[i] = 1'b1;
                        w_tie_nxt       = 1'b1;
                    end
                end else if (tom_hit[i]) begin
                    w_tom_cred[i] = 1'b1;
                end else begin
                    w_jerry_cred[i] = 1'b1;
                end
            end
        end
    end

    assign w_tom_sum   = {1'b0, r_tom_score} + (SCORE_W+1)'(w_tom_cred[0])
                       + (SCORE_W+1)'(w_tom_cred[1]);
    assign w_jerry_sum = {1'b0, r_jerry_score} + (SCORE_W+1)'(w_jerry_cred[0])
                       + (SCORE_W+1)'(w_jerry_cred[1]);
    assign w_tom_nxt   = (w_tom_sum > MAX_W) ? MAX_S : w_tom_sum[SCORE_W-1:0];
    assign w_jerry_nxt = (w_jerry_sum > MAX_W) ? MAX_S : w_jerry_sum[SCORE_W-1:0];
    assign w_go_nxt    = r_game_over | (w_tom_nxt == MAX_S) | (w_jerry_nxt == MAX_S);

    // randomx_plat ignores 2'b11, so at most one grant per cycle.
    always_comb begin
        w_grant = 2'b00;
        if (w_run) begin
            if (&w_req) w_grant = r_last_grant ? 2'b01 : 2'b10;
            else        w_grant = w_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tom_score   <= '0;
            r_jerry_score <= '0;
            r_game_over   <= 1'b0;
            r_winner      <= 2'b00;
            r_tie_last    <= 1'b1;
            r_last_grant  <= 1'b1;
        end else begin
            r_tom_score   <= w_tom_nxt;
            r_jerry_score <= w_jerry_nxt;
            r_tie_last    <= w_tie_nxt;
            r_game_over   <= w_go_nxt;
            if (|w_grant) r_last_grant <= w_grant[1];
            if (!r_game_over && w_go_nxt)
                r_winner <= (w_jerry_nxt == MAX_S && w_tom_nxt != MAX_S) ? 2'b10 : 2'b01;
        end
    end

    cheese_slot_fsm #(.RESPAWN_DELAY(RESPAWN_DELAY)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .i_hit     (w_hit[0]),
        .i_grant   (w_grant[0]),
        .i_game_en (game_en),
        .i_halt    (w_go_nxt),
        .o_vis     (w_vis[0]),
        .o_req     (w_req[0]),
        .o_pulse   (w_pulse[0]),
        .o_state   (w_state0)
    );

    cheese_slot_fsm #(.RESPAWN_DELAY(RESPAWN_DELAY)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .i_hit     (w_hit[1]),
        .i_grant   (w_grant[1]),
        .i_game_en (game_en),
        .i_halt    (w_go_nxt),
        .o_vis     (w_vis[1]),
        .o_req     (w_req[1]),
        .o_pulse   (w_pulse[1]),
        .o_state   (w_state1)
    );

    assign rnd_generate = w_pulse;
    assign cheese_vis   = w_vis;
    assign tom_score    = r_tom_score;
    assign jerry_score  = r_jerry_score;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign o_dbg_state  = {w_state1, w_state0};

endmodule

// File: tb/tb_cheese_spawn_ctrl.sv
// Bench for cheese_spawn_ctrl: directed scenarios plus random play, all checked
// every cycle against a time-based behavioural model.
module tb_cheese_spawn_ctrl;

    localparam int D    = 4;
    localparam int SW   = 8;
    localparam int MAXS = 3;

    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_WAIT  = 2;
    localparam int M_SPAWN = 3;
    localparam int M_HALT  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          game_en = 1'b0;
    logic [1:0]    tom_hit = 2'b00;
    logic [1:0]    jerry_hit = 2'b00;
    logic [1:0]    rnd_generate;
    logic [1:0]    cheese_vis;
    logic [SW-1:0] tom_score;
    logic [SW-1:0] jerry_score;
    logic          game_over;
    logic [1:0]    winner;
    logic [5:0]    o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*SW+6:0] exp_q[$];

    // Model: per-slot mode plus an absolute edge number for the next event.
    int   m_mode[2];
    int   m_t[2];
    int   m_edge = 0;
    int   m_tom = 0;
    int   m_jerry = 0;
    bit   m_go = 0;
    logic [1:0] m_win = 2'b00;
    bit   m_tie_jerry = 1;
    int   m_last_slot = 1;

    cheese_spawn_ctrl #(.RESPAWN_DELAY(D), .SCORE_W(SW), .MAX_SCORE(MAXS)) dut (
        .clk          (clk),
        .rst          (rst),
        .game_en      (game_en),
        .tom_hit      (tom_hit),
        .jerry_hit    (jerry_hit),
        .rnd_generate (rnd_generate),
        .cheese_vis   (cheese_vis),
        .tom_score    (tom_score),
        .jerry_score  (jerry_score),
        .game_over    (game_over),
        .winner       (winner),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural model
    always @(posedge clk or posedge rst) begin : model
        int tc, jc, g;
        bit run, c0, c1;
        logic [1:0] eaten, pulse, vis;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin m_mode[i] = M_OFF; m_t[i] = 0; end
            m_edge = 0; m_tom = 0; m_jerry = 0; m_go = 0; m_win = 2'b00;
            m_tie_jerry = 1; m_last_slot = 1;
            exp_q.delete();
        end else begin
            m_edge++;
            run = game_en && !m_go;
            tc = 0; jc = 0; eaten = 2'b00; pulse = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (run && m_mode[i] == M_ON && (tom_hit[i] || jerry_hit[i])) begin
                    eaten[i] = 1'b1;
                    if (tom_hit[i] && jerry_hit[i]) begin
                        if (m_tie_jerry) begin tc++; m_tie_jerry = 0; end
                        else             begin jc++; m_tie_jerry = 1; end
                    end else if (tom_hit[i]) tc++;
                    else jc++;
                end
            end
            m_tom   = (m_tom + tc > MAXS) ? MAXS : m_tom + tc;
            m_jerry = (m_jerry + jc > MAXS) ? MAXS : m_jerry + jc;
            if (!m_go && (m_tom == MAXS || m_jerry == MAXS)) begin
                m_go  = 1;
                m_win = (m_tom == MAXS) ? 2'b01 : 2'b10;
            end
            if (m_go) begin
                m_mode[0] = M_HALT; m_mode[1] = M_HALT;
            end else if (!game_en) begin
                m_mode[0] = M_OFF; m_mode[1] = M_OFF;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_mode[i] == M_OFF) m_mode[i] = M_ON;
                    else if (m_mode[i] == M_ON && eaten[i]) begin
                        m_mode[i] = M_WAIT; m_t[i] = m_edge + D + 1;
                    end else if (m_mode[i] == M_SPAWN && m_edge >= m_t[i]) m_mode[i] = M_ON;
                end
                c0 = (m_mode[0] == M_WAIT) && (m_t[0] <= m_edge);
                c1 = (m_mode[1] == M_WAIT) && (m_t[1] <= m_edge);
                g = -1;
                if (c0 && c1) g = (m_last_slot == 1) ? 0 : 1;
                else if (c0)  g = 0;
                else if (c1)  g = 1;
                if (g >= 0) begin
                    pulse[g] = 1'b1; m_mode[g] = M_SPAWN; m_t[g] = m_edge + 2; m_last_slot = g;
                end
            end
            vis = {m_mode[1] == M_ON, m_mode[0] == M_ON};
            exp_q.push_back({pulse, vis, SW'(m_tom), SW'(m_jerry), m_go, m_win});
        end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin : compare
        logic [2*SW+6:0] e, got;
        if (!rst && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {rnd_generate, cheese_vis, tom_score, jerry_score, game_over, winner};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got rnd=%b vis=%b tom=%0d jerry=%0d go=%b win=%b exp rnd=%b vis=%b tom=%0d jerry=%0d go=%b win=%b",
                         $time, got[2*SW+6:2*SW+5], got[2*SW+4:2*SW+3], got[2*SW+2:SW+3],
                         got[SW+2:3], got[2], got[1:0], e[2*SW+6:2*SW+5], e[2*SW+4:2*SW+3],
                         e[2*SW+2:SW+3], e[SW+2:3], e[2], e[1:0]);
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] th, input logic [1:0] jh);
        game_en = en; tom_hit = th; jerry_hit = jh;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1; game_en = 1'b0; tom_hit = 2'b00; jerry_hit = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        int pk, vk, np, p0, p1, bad;
        bit found;
        do_reset();
        chk("reset_rnd", rnd_generate, 0);
        chk("reset_vis", cheese_vis, 0);
        chk("reset_scores", {tom_score, jerry_score}, 0);
        chk("reset_go_win", {game_over, winner}, 0);

        // single pickup and respawn timing
        step(1'b1, 2'b00, 2'b00);
        chk("vis_on", cheese_vis, 3);
        step(1'b1, 2'b01, 2'b00);
        chk("tom_first_point", tom_score, 1);
        chk("vis_after_hit", cheese_vis, 2);
        pk = 0; vk = 0; np = 0;
        for (int k = 2; k <= 12; k++) begin
            step(1'b1, 2'b00, 2'b00);
            if (rnd_generate != 2'b00) begin
                np++;
                if (pk == 0) pk = k;
                chk("pulse_slot0", rnd_generate, 1);
            end
            if (vk == 0 && cheese_vis == 2'b11) vk = k;
        end
        chk("pulse_cycle", pk, 6);
        chk("pulse_count", np, 1);
        chk("revisible_cycle", vk, 8);

        // tie alternation
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b01);
        chk("tie1_scores", {tom_score, jerry_score}, {8'd1, 8'd0});
        idle(8);
        chk("tie_respawned", cheese_vis, 3);
        step(1'b1, 2'b01, 2'b01);
        chk("tie2_scores", {tom_score, jerry_score}, {8'd1, 8'd1});

        // both slots eaten together
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b11, 2'b00);
        chk("double_score", tom_score, 2);
        chk("double_vis", cheese_vis, 0);
        p0 = 0; p1 = 0; bad = 0;
        for (int k = 2; k <= 12; k++) begin
            step(1'b1, 2'b00, 2'b00);
            if (rnd_generate == 2'b11) bad++;
            if (rnd_generate == 2'b01 && p0 == 0) p0 = k;
            if (rnd_generate == 2'b10 && p1 == 0) p1 = k;
        end
        chk("arb_first_slot0", p0, 6);
        chk("arb_then_slot1", p1, 7);
        chk("arb_never_11", bad, 0);
        chk("double_revisible", cheese_vis, 3);

        // Jerry reaches MAX_SCORE
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 2'b01);
            if (i < 2) idle(9);
        end
        chk("jerry_max", jerry_score, MAXS);
        chk("go_set", game_over, 1);
        chk("winner_jerry", winner, 2);
        chk("halt_vis", cheese_vis, 0);
        np = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (rnd_generate != 2'b00) np++;
        end
        chk("halt_no_pulse", np, 0);
        chk("halt_scores", {tom_score, jerry_score}, {8'd0, 8'd3});

        // game_en dropped while hidden
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b01);
        step(1'b1, 2'b00, 2'b00);
        np = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 2'b11, 2'b11);
            if (rnd_generate != 2'b00) np++;
        end
        chk("disabled_no_pulse", np, 0);
        chk("disabled_vis", cheese_vis, 0);
        chk("disabled_scores", {tom_score, jerry_score}, {8'd0, 8'd1});
        step(1'b1, 2'b00, 2'b00);
        chk("reenable_vis", cheese_vis, 3);
        np = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'b00, 2'b00);
            if (rnd_generate != 2'b00) np++;
        end
        chk("reenable_no_stale_req", np, 0);

        // Tom saturates at MAX_SCORE
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b00);
        idle(9);
        step(1'b1, 2'b01, 2'b00);
        idle(9);
        step(1'b1, 2'b11, 2'b00);
        chk("tom_saturated", tom_score, MAXS);
        chk("winner_tom", {game_over, winner}, 3'b101);

        // both reach MAX_SCORE on one edge
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 2'b10);
            if (i < 2) idle(9);
        end
        chk("both_max_scores", {tom_score, jerry_score}, {8'd3, 8'd3});
        chk("both_max_winner_tom", {game_over, winner}, 3'b101);

        // reset during a pulse
        do_reset();
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b00);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1'b1, 2'b00, 2'b00);
            if (rnd_generate != 2'b00) found = 1;
        end
        chk("pulse_seen_before_rst", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_truncates_pulse", rnd_generate, 0);
        chk("rst_vis", cheese_vis, 0);
        chk("rst_scores", {tom_score, jerry_score}, 0);
        chk("rst_go_win", {game_over, winner}, 0);
        @(negedge clk);
        rst = 1'b0;

        // random play
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                step($urandom_range(0, 15) != 0,
                     {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                     {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
            end
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
